// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core.
// Holds the opcode constants used by ImmExt and the control decoder, the
// canonical NOP encoding, and the instruction fetch state encoding.
package riscv_pkg;

  localparam logic [6:0] LUI_OP    = 7'b0110111;
  localparam logic [6:0] AUIPC_OP  = 7'b0010111;
  localparam logic [6:0] JAL_OP    = 7'b1101111;
  localparam logic [6:0] JALR_OP   = 7'b1100111;
  localparam logic [6:0] BRANCH_OP = 7'b1100011;
  localparam logic [6:0] LW_OP     = 7'b0000011;
  localparam logic [6:0] SW_OP     = 7'b0100011;
  localparam logic [6:0] ALUI_OP   = 7'b0010011;
  localparam logic [6:0] ALUR_OP   = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding at mem_addr
    ST_HOLD  = 2'd1,  // instruction register valid, waiting for decode
    ST_DRAIN = 2'd2,  // redirected mid-access, waiting to discard the ack
    ST_ERR   = 2'd3   // misaligned target, halted until aligned redirect
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage of the multicycle RV32I core.
// Owns the PC, issues word reads over a req/ack handshake and holds the
// fetched word in the instruction register presented to decode.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_req/mem_addr         read request and word address to instruction memory
//   mem_ack/mem_rdata        one-cycle ack with read data
//   redirect_valid/_pc       taken branch / jal / jalr target from execute
//   instr_valid/instr_ready  handshake towards decode
//   instr/instr_pc           instruction register and its address
//   fetch_error              misaligned fetch target, fetching halted
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_error
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  // Address of the outstanding request; kept separately from pc because a
  // redirect during DRAIN updates pc while the bus address must stay put.
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         go_fetch;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= NOP_INSTR;
      ipc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    go_fetch = 1'b0;

    // A redirect always retargets pc, whatever the state.
    if (redirect_valid) pc_d = redirect_pc;

    unique case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          // Returned word (if any) belongs to the squashed path.
          if (mem_ack) go_fetch = 1'b1;
          else         state_d  = ST_DRAIN;
        end else if (mem_ack) begin
          instr_d = mem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Redirect wins over a same-cycle accept.
        if (redirect_valid || instr_ready) go_fetch = 1'b1;
      end
      ST_DRAIN: begin
        if (mem_ack) go_fetch = 1'b1;
      end
      ST_ERR: begin
        // Misaligned redirects are caught by the entry check below.
        if (redirect_valid) go_fetch = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase

    // Alignment check on every entry to FETCH.
    if (go_fetch) begin
      if (pc_d[1:0] != 2'b00) begin
        state_d = ST_ERR;
      end else begin
        state_d = ST_FETCH;
        addr_d  = pc_d;
      end
    end
  end

  // Outputs, decoded from state and registers only
  always_comb begin
    mem_req     = !rst && (state_q == ST_FETCH || state_q == ST_DRAIN);
    mem_addr    = addr_q;
    instr_valid = (state_q == ST_HOLD);
    fetch_error = (state_q == ST_ERR);
    instr       = instr_q;
    instr_pc    = ipc_q;
  end

endmodule
